// File: rtl/spi_pkg.sv
// spi_pkg: definitions shared by the SPI slave files.
//   spi_state_t   - slave FSM state encoding
//   CPOL_*/CPHA_* - clock polarity / phase mode constants
//   SETTLE_CYCLES - clocks until the synchronizer pipeline holds only pin-derived values
package spi_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } spi_state_t;

    localparam bit CPOL_LOW   = 1'b0;
    localparam bit CPOL_HIGH  = 1'b1;
    localparam bit CPHA_LEAD  = 1'b0;
    localparam bit CPHA_TRAIL = 1'b1;

    localparam int SETTLE_CYCLES = 3;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: two-flop synchronizer for an asynchronous input plus
// rise/fall detection on the synchronized value.
//   clk   - system clock
//   rst   - synchronous active-high reset; all flops load RESET_VAL
//   raw   - asynchronous input
//   level - synchronized value
//   rise  - one-cycle pulse on a synchronized 0->1 transition
//   fall  - one-cycle pulse on a synchronized 1->0 transition
module spi_sync_edge
    import spi_pkg::*;
#(
    parameter bit RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic rise,
    output logic fall
);

    logic meta;
    logic prev;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta  <= RESET_VAL;
            level <= RESET_VAL;
            prev  <= RESET_VAL;
        end else begin
            meta  <= raw;
            level <= meta;
            prev  <= level;
        end
    end

    assign rise = level & ~prev;
    assign fall = ~level & prev;

endmodule

// File: rtl/spi_slave.sv
// spi_slave: oversampled SPI slave with valid/ready word interfaces.
//
// state     | meaning
// ----------+-------------------------------------------
// ST_IDLE   | ss high (or not yet seen high after reset)
// ST_ACTIVE | ss low, shifting frames of DATA_W bits
//
// Ports:
//   clk_in, rst_in                 - system clock, synchronous active-high reset
//   sck_in, ss_in, mosi_in         - asynchronous SPI pins from the master
//   miso_out, miso_oe_out          - serial data / output enable to the master
//   tx_data_in, tx_valid_in,
//   tx_ready_out                   - load handshake into the single-word TX holding register
//   rx_data_out, rx_valid_out,
//   rx_ready_in                    - received word handshake
//   rx_overrun_out, tx_underrun_out - single-cycle error pulses
module spi_slave
    import spi_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter bit CPOL      = CPOL_LOW,
    parameter bit CPHA      = CPHA_LEAD,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              sck_in,
    input  logic              ss_in,
    input  logic              mosi_in,
    output logic              miso_out,
    output logic              miso_oe_out,
    input  logic [DATA_W-1:0] tx_data_in,
    input  logic              tx_valid_in,
    output logic              tx_ready_out,
    output logic [DATA_W-1:0] rx_data_out,
    output logic              rx_valid_out,
    input  logic              rx_ready_in,
    output logic              rx_overrun_out,
    output logic              tx_underrun_out
);

    localparam int CNT_W = $clog2(DATA_W);

    spi_state_t        state, next_state;
    logic              sck_sync, sck_rise, sck_fall;
    logic              ss_sync, ss_rise, ss_fall;
    logic              mosi_meta, mosi_sync;
    logic [1:0]        settle;
    logic              armed;
    logic              leading, trailing;
    logic              start, sample, drive, wrap;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] hold, load_word, load_rest, tx_shift, tx_rest;
    logic [DATA_W-1:0] rx_shift, rx_next;
    logic              hold_full, filler, miso_bit, load_first, tx_first;

    spi_sync_edge #(.RESET_VAL(CPOL)) u_sck_sync (
        .clk(clk_in), .rst(rst_in), .raw(sck_in),
        .level(sck_sync), .rise(sck_rise), .fall(sck_fall)
    );

    spi_sync_edge #(.RESET_VAL(1'b1)) u_ss_sync (
        .clk(clk_in), .rst(rst_in), .raw(ss_in),
        .level(ss_sync), .rise(ss_rise), .fall(ss_fall)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            mosi_meta <= 1'b1;
            mosi_sync <= 1'b1;
        end else begin
            mosi_meta <= mosi_in;
            mosi_sync <= mosi_meta;
        end
    end

    // The ss synchronizer resets to 1, so a pin already low at reset release
    // would look like a falling edge. Arm only once ss is seen high after the
    // pipeline has flushed, so a frame needs a genuine ss falling edge.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            settle <= '0;
            armed  <= 1'b0;
        end else begin
            if (settle != 2'(SETTLE_CYCLES))
                settle <= settle + 2'd1;
            if (settle == 2'(SETTLE_CYCLES) && ss_sync)
                armed <= 1'b1;
        end
    end

    assign leading  = (sck_rise | sck_fall) & (sck_sync != CPOL);
    assign trailing = (sck_rise | sck_fall) & (sck_sync == CPOL);

    always_ff @(posedge clk_in) begin
        if (rst_in)
            state <= ST_IDLE;
        else
            state <= next_state;
    end

    always_comb begin
        next_state = state;
        start      = 1'b0;
        sample     = 1'b0;
        drive      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ss_fall && armed) begin
                    next_state = ST_ACTIVE;
                    start      = 1'b1;
                end
            end
            ST_ACTIVE: begin
                // SCK edges coinciding with ss release belong to no frame.
                if (ss_rise) begin
                    next_state = ST_IDLE;
                end else begin
                    sample = (CPHA == CPHA_LEAD) ? leading : trailing;
                    drive  = (CPHA == CPHA_LEAD) ? trailing : leading;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    assign wrap = sample && (bit_cnt == CNT_W'(DATA_W - 1));

    always_comb begin
        load_word = hold_full ? hold : '1;
        if (MSB_FIRST) begin
            load_first = load_word[DATA_W-1];
            load_rest  = {load_word[DATA_W-2:0], 1'b1};
            tx_first   = tx_shift[DATA_W-1];
            tx_rest    = {tx_shift[DATA_W-2:0], 1'b1};
            rx_next    = {rx_shift[DATA_W-2:0], mosi_sync};
        end else begin
            load_first = load_word[0];
            load_rest  = {1'b1, load_word[DATA_W-1:1]};
            tx_first   = tx_shift[0];
            tx_rest    = {1'b1, tx_shift[DATA_W-1:1]};
            rx_next    = {mosi_sync, rx_shift[DATA_W-1:1]};
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in)
            bit_cnt <= '0;
        else if (state != ST_ACTIVE || ss_rise)
            bit_cnt <= '0;
        else if (sample)
            bit_cnt <= wrap ? '0 : bit_cnt + CNT_W'(1);
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            hold      <= '0;
            hold_full <= 1'b0;
        end else if (tx_valid_in && !hold_full) begin
            hold      <= tx_data_in;
            hold_full <= 1'b1;
        end else if (start || wrap) begin
            hold_full <= 1'b0;
        end
    end

    // A frame boundary at the end of a transfer loads the shifter (filler if
    // nothing is held) but may never be clocked; the underrun is reported on
    // the first sample of a filler frame so only frames the master actually
    // clocks raise it.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            tx_shift        <= '1;
            miso_bit        <= 1'b1;
            filler          <= 1'b0;
            tx_underrun_out <= 1'b0;
        end else begin
            tx_underrun_out <= sample && (bit_cnt == '0) && filler;
            if (start) begin
                filler <= !hold_full;
                if (CPHA == CPHA_LEAD) begin
                    miso_bit <= load_first;
                    tx_shift <= load_rest;
                end else begin
                    tx_shift <= load_word;
                end
            end else if (wrap) begin
                // Next frame's first bit goes out on the following drive edge.
                filler   <= !hold_full;
                tx_shift <= load_word;
            end else if (drive) begin
                miso_bit <= tx_first;
                tx_shift <= tx_rest;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            rx_shift       <= '0;
            rx_data_out    <= '0;
            rx_valid_out   <= 1'b0;
            rx_overrun_out <= 1'b0;
        end else begin
            rx_overrun_out <= 1'b0;
            if (sample)
                rx_shift <= rx_next;
            if (wrap) begin
                rx_data_out    <= rx_next;
                rx_valid_out   <= 1'b1;
                rx_overrun_out <= rx_valid_out && !rx_ready_in;
            end else if (rx_valid_out && rx_ready_in) begin
                rx_valid_out <= 1'b0;
            end
        end
    end

    assign miso_oe_out  = (state == ST_ACTIVE);
    assign miso_out     = miso_oe_out ? miso_bit : 1'b1;
    assign tx_ready_out = !hold_full;

endmodule
